// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline latch and register-file write-data formation.
// Presents WEN/wsel/wdat after the rising edge so the register file can commit
// them on the following falling edge. It also extends sub-word loads, keeps a
// sticky halt flag and counts retired instructions.
module wb_stage #(
  parameter int RA_W = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            enable,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_regwrite,
  input  logic [RA_W-1:0] in_wsel,
  input  logic [1:0]      in_wbsrc,
  input  logic [1:0]      in_ldsize,
  input  logic            in_ldsigned,
  input  logic [1:0]      in_addrlo,
  input  logic [31:0]     in_aluout,
  input  logic [31:0]     in_dload,
  input  logic [31:0]     in_npc,
  input  logic [15:0]     in_imm16,
  input  logic            in_halt,
  output logic            WEN,
  output logic [RA_W-1:0] wsel,
  output logic [31:0]     wdat,
  output logic            halt,
  output logic [31:0]     retire_cnt
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;
  localparam logic [1:0] SRC_LUI  = 2'b11;

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  logic            valid_q,    valid_d;
  logic            regwrite_q, regwrite_d;
  logic [RA_W-1:0] wsel_q,     wsel_d;
  logic [1:0]      wbsrc_q,    wbsrc_d;
  logic [1:0]      ldsize_q,   ldsize_d;
  logic            ldsigned_q, ldsigned_d;
  logic [1:0]      addrlo_q,   addrlo_d;
  logic [31:0]     aluout_q,   aluout_d;
  logic [31:0]     dload_q,    dload_d;
  logic [31:0]     npc_q,      npc_d;
  logic [15:0]     imm16_q,    imm16_d;
  logic            isHalt_q,   isHalt_d;
  logic            halt_q,     halt_d;
  logic [31:0]     retire_q,   retire_d;

  logic            capture;
  logic [15:0]     halfLane;
  logic [7:0]      byteLane;
  logic [31:0]     loadData;

  // Next-state: halt freezes everything, flush inserts a bubble, enable captures.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    wsel_d     = wsel_q;
    wbsrc_d    = wbsrc_q;
    ldsize_d   = ldsize_q;
    ldsigned_d = ldsigned_q;
    addrlo_d   = addrlo_q;
    aluout_d   = aluout_q;
    dload_d    = dload_q;
    npc_d      = npc_q;
    imm16_d    = imm16_q;
    isHalt_d   = isHalt_q;
    halt_d     = halt_q;
    retire_d   = retire_q;
    capture    = 1'b0;
    if (!halt_q) begin
      if (flush) begin
        valid_d = 1'b0;
      end else if (enable) begin
        capture    = 1'b1;
        valid_d    = in_valid;
        regwrite_d = in_regwrite;
        wsel_d     = in_wsel;
        wbsrc_d    = in_wbsrc;
        ldsize_d   = in_ldsize;
        ldsigned_d = in_ldsigned;
        addrlo_d   = in_addrlo;
        aluout_d   = in_aluout;
        dload_d    = in_dload;
        npc_d      = in_npc;
        imm16_d    = in_imm16;
        isHalt_d   = in_halt;
      end
    end
    if (capture && in_valid) begin
      retire_d = retire_q + 32'd1;
      if (in_halt) begin
        halt_d = 1'b1;
      end
    end
  end

  // Pipeline latch, sticky halt and retire counter; reset is asynchronous.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wsel_q     <= '0;
      wbsrc_q    <= 2'b00;
      ldsize_q   <= 2'b00;
      ldsigned_q <= 1'b0;
      addrlo_q   <= 2'b00;
      aluout_q   <= 32'd0;
      dload_q    <= 32'd0;
      npc_q      <= 32'd0;
      imm16_q    <= 16'd0;
      isHalt_q   <= 1'b0;
      halt_q     <= 1'b0;
      retire_q   <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wsel_q     <= wsel_d;
      wbsrc_q    <= wbsrc_d;
      ldsize_q   <= ldsize_d;
      ldsigned_q <= ldsigned_d;
      addrlo_q   <= addrlo_d;
      aluout_q   <= aluout_d;
      dload_q    <= dload_d;
      npc_q      <= npc_d;
      imm16_q    <= imm16_d;
      isHalt_q   <= isHalt_d;
      halt_q     <= halt_d;
      retire_q   <= retire_d;
    end
  end

  // Big-endian lane selection and extension for sub-word loads.
  always_comb begin
    halfLane = addrlo_q[1] ? dload_q[15:0] : dload_q[31:16];
    byteLane = 8'd0;
    case (addrlo_q)
      2'd0:    byteLane = dload_q[31:24];
      2'd1:    byteLane = dload_q[23:16];
      2'd2:    byteLane = dload_q[15:8];
      default: byteLane = dload_q[7:0];
    endcase
    loadData = dload_q;
    if (ldsize_q == SIZE_HALF) begin
      loadData = {{16{ldsigned_q & halfLane[15]}}, halfLane};
    end else if (ldsize_q == SIZE_BYTE) begin
      loadData = {{24{ldsigned_q & byteLane[7]}}, byteLane};
    end
  end

  // Write-data source mux.
  always_comb begin
    wdat = aluout_q;
    case (wbsrc_q)
      SRC_ALU:  wdat = aluout_q;
      SRC_LOAD: wdat = loadData;
      SRC_LINK: wdat = npc_q;
      SRC_LUI:  wdat = {imm16_q, 16'h0000};
      default:  wdat = aluout_q;
    endcase
  end

  assign WEN        = valid_q & regwrite_q & (wsel_q != '0) & ~halt_q;
  assign wsel       = wsel_q;
  assign halt       = halt_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for the writeback stage.
module tb_wb_stage;

  logic        CLK;
  logic        RST;
  logic        enable;
  logic        flush;
  logic        in_valid;
  logic        in_regwrite;
  logic [4:0]  in_wsel;
  logic [1:0]  in_wbsrc;
  logic [1:0]  in_ldsize;
  logic        in_ldsigned;
  logic [1:0]  in_addrlo;
  logic [31:0] in_aluout;
  logic [31:0] in_dload;
  logic [31:0] in_npc;
  logic [15:0] in_imm16;
  logic        in_halt;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic        halt;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage #(.RA_W(5)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_wsel(in_wsel),
    .in_wbsrc(in_wbsrc), .in_ldsize(in_ldsize), .in_ldsigned(in_ldsigned),
    .in_addrlo(in_addrlo), .in_aluout(in_aluout), .in_dload(in_dload),
    .in_npc(in_npc), .in_imm16(in_imm16), .in_halt(in_halt),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .halt(halt), .retire_cnt(retire_cnt)
  );

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: timeout reached, required finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  // Load one slot onto the inputs (stimulus only).
  task automatic drive(input logic v, input logic rw, input logic [4:0] ws,
                       input logic [1:0] src, input logic [1:0] sz, input logic sg,
                       input logic [1:0] al, input logic [31:0] alu,
                       input logic [31:0] dl, input logic [31:0] pc,
                       input logic [15:0] imm, input logic hlt);
    in_valid = v; in_regwrite = rw; in_wsel = ws; in_wbsrc = src;
    in_ldsize = sz; in_ldsigned = sg; in_addrlo = al; in_aluout = alu;
    in_dload = dl; in_npc = pc; in_imm16 = imm; in_halt = hlt;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; enable = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    #3;
    checks++; if (WEN !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got %0h want 0", WEN); end
    checks++; if (wsel !== 5'd0) begin errors++; $display("[TB] FAIL reset_wsel got %0h want 0", wsel); end
    checks++; if (wdat !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdat got %h want 0", wdat); end
    checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt got %0h want 0", halt); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", retire_cnt); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_alu_write();
    enable = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 2'b00, 32'h1234_5678, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    checks++; if (WEN !== 1'b1) begin errors++; $display("[TB] FAIL alu_wen got %0h want 1", WEN); end
    checks++; if (wsel !== 5'd5) begin errors++; $display("[TB] FAIL alu_wsel got %0d want 5", wsel); end
    checks++; if (wdat !== 32'h1234_5678) begin errors++; $display("[TB] FAIL alu_wdat got %h want 12345678", wdat); end
    checks++; if (retire_cnt !== 32'd1) begin errors++; $display("[TB] FAIL alu_cnt got %0d want 1", retire_cnt); end
  endtask

  task automatic test_load();
    logic [1:0]  sz [5];
    logic        sg [5];
    logic [1:0]  al [5];
    logic [31:0] exp [5];
    sz[0] = 2'b10; sg[0] = 1'b1; al[0] = 2'd0; exp[0] = 32'hFFFF_FF80;
    sz[1] = 2'b10; sg[1] = 1'b0; al[1] = 2'd2; exp[1] = 32'h0000_007F;
    sz[2] = 2'b01; sg[2] = 1'b1; al[2] = 2'd2; exp[2] = 32'h0000_7F01;
    sz[3] = 2'b01; sg[3] = 1'b1; al[3] = 2'd0; exp[3] = 32'hFFFF_80FF;
    sz[4] = 2'b00; sg[4] = 1'b1; al[4] = 2'd1; exp[4] = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 5'd3, 2'b01, sz[i], sg[i], al[i], 32'h5555_AAAA, 32'h80FF_7F01, 32'd0, 16'd0, 1'b0);
      step();
      checks++;
      if (wdat !== exp[i]) begin
        errors++; $display("[TB] FAIL load_%0d got %h want %h", i, wdat, exp[i]);
      end
    end
    checks++; if (retire_cnt !== 32'd6) begin errors++; $display("[TB] FAIL load_cnt got %0d want 6", retire_cnt); end
  endtask

  task automatic test_lui_link_zero();
    drive(1'b1, 1'b1, 5'd8, 2'b11, 2'b00, 1'b0, 2'b00, 32'h0BAD_0BAD, 32'd0, 32'd0, 16'hABCD, 1'b0);
    step();
    checks++; if (wdat !== 32'hABCD_0000) begin errors++; $display("[TB] FAIL lui_wdat got %h want abcd0000", wdat); end
    drive(1'b1, 1'b1, 5'd31, 2'b10, 2'b00, 1'b0, 2'b00, 32'h0BAD_0BAD, 32'd0, 32'h0000_0044, 16'd0, 1'b0);
    step();
    checks++; if (wdat !== 32'h0000_0044) begin errors++; $display("[TB] FAIL jal_wdat got %h want 44", wdat); end
    checks++; if (WEN !== 1'b1) begin errors++; $display("[TB] FAIL jal_wen got %0h want 1", WEN); end
    drive(1'b1, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00, 32'hDEAD_BEEF, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    checks++; if (WEN !== 1'b0) begin errors++; $display("[TB] FAIL zero_wen got %0h want 0", WEN); end
    checks++; if (wdat !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL zero_wdat got %h want deadbeef", wdat); end
    drive(1'b0, 1'b1, 5'd6, 2'b00, 2'b00, 1'b0, 2'b00, 32'h1111_2222, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    checks++; if (WEN !== 1'b0) begin errors++; $display("[TB] FAIL bubble_wen got %0h want 0", WEN); end
    checks++; if (retire_cnt !== 32'd9) begin errors++; $display("[TB] FAIL bubble_cnt got %0d want 9", retire_cnt); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 5'd7, 2'b00, 2'b00, 1'b0, 2'b00, 32'hCAFE_0001, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    enable = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 2'b00, 2'b00, 1'b0, 2'b00, 32'h1111_1111, 32'd0, 32'd0, 16'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'hCAFE_0001 || retire_cnt !== 32'd10) begin
        errors++;
        $display("[TB] FAIL stall_%0d got wen=%0h wsel=%0d wdat=%h cnt=%0d want 1/7/cafe0001/10",
                 c, WEN, wsel, wdat, retire_cnt);
      end
    end
    enable = 1'b1; flush = 1'b1;
    step();
    checks++; if (WEN !== 1'b0) begin errors++; $display("[TB] FAIL flush_wen got %0h want 0", WEN); end
    checks++; if (retire_cnt !== 32'd10) begin errors++; $display("[TB] FAIL flush_cnt got %0d want 10", retire_cnt); end
    flush = 1'b0;
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1);
    step();
    checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halt_set got %0h want 1", halt); end
    checks++; if (retire_cnt !== 32'd11) begin errors++; $display("[TB] FAIL halt_cnt got %0d want 11", retire_cnt); end
    drive(1'b1, 1'b1, 5'd4, 2'b00, 2'b00, 1'b0, 2'b00, 32'h7777_7777, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    step();
    checks++; if (WEN !== 1'b0) begin errors++; $display("[TB] FAIL halted_wen got %0h want 0", WEN); end
    checks++; if (retire_cnt !== 32'd11) begin errors++; $display("[TB] FAIL halted_cnt got %0d want 11", retire_cnt); end
    checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL halted_sticky got %0h want 1", halt); end
    enable = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL async_halt got %0h want 0", halt); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("[TB] FAIL async_cnt got %0d want 0", retire_cnt); end
    checks++; if (wdat !== 32'd0) begin errors++; $display("[TB] FAIL async_wdat got %h want 0", wdat); end
    #1;
    RST = 1'b0;
  endtask

  task automatic test_wrap();
    step();
    dut.retire_q = 32'hFFFF_FFFF;
    #1;
    checks++; if (retire_cnt !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_preload got %h want ffffffff", retire_cnt); end
    enable = 1'b1;
    drive(1'b1, 1'b1, 5'd2, 2'b00, 2'b00, 1'b0, 2'b00, 32'h0000_00AA, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("[TB] FAIL wrap_cnt got %h want 0", retire_cnt); end
    checks++; if (WEN !== 1'b1) begin errors++; $display("[TB] FAIL wrap_wen got %0h want 1", WEN); end
    enable = 1'b0;
  endtask

  // Run each scenario in order and report.
  initial begin
    test_reset();
    test_alu_write();
    test_load();
    test_lui_link_zero();
    test_stall_flush();
    test_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
